// File: rtl/dmac_multi_chan_ctrl.sv
`default_nettype none
//==============================================================================
// Module : dmac_multi_chan_ctrl
// Brief  : N-channel DMA main controller. Handles request arbitration, the bus handshake,
//          grant timeout and the completion interrupt. Define DMAC_RR_ARB_EN for
//          round-robin arbitration; otherwise the highest channel index wins.
// Rev    : 1.0
//==============================================================================
module dmac_multi_chan_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int TMO_W         = 8,
  parameter int GRANT_TIMEOUT = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         dmac_req,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic                      bus_grant,
  input  logic                      c_config,
  input  logic                      ch_done,
  input  logic                      con_new_sel,
  output logic                      bus_req,
  output logic                      hold,
  output logic                      con_en,
  output logic                      con_sel,
  output logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         req_ack,
  output logic [$clog2(NUM_CH)-1:0] active_ch,
  output logic                      interrupt,
  output logic                      timeout_err
);

  localparam int                IDX_W      = $clog2(NUM_CH);
  localparam logic [TMO_W-1:0]  C_TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] C_ONE      = NUM_CH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_cnt_nxt;
  logic [IDX_W-1:0]  r_active_ch, w_active_nxt;
  logic              r_bus_req, w_bus_req_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_con_en, w_con_en_nxt;
  logic [NUM_CH-1:0] r_ch_en, w_ch_en_nxt;
  logic [NUM_CH-1:0] r_req_ack, w_req_ack_nxt;
  logic              r_irq, w_irq_nxt;
  logic              r_tmo_err, w_tmo_err_nxt;
  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_onehot;
  logic [IDX_W-1:0]  w_win;

  assign w_elig   = dmac_req & ch_mask;
  assign w_onehot = C_ONE << r_active_ch;

`ifdef DMAC_RR_ARB_EN
  logic [IDX_W-1:0] r_rr_ptr;

  function automatic logic [IDX_W-1:0] f_wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    return IDX_W'(sum);
  endfunction

  // Descending offsets so the channel closest after the pointer is assigned last.
  always_comb begin
    w_win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_elig[f_wrap_idx(r_rr_ptr, k)]) w_win = f_wrap_idx(r_rr_ptr, k);
    end
  end

  // Only a real acknowledge advances the pointer; aborts and timeouts leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rr_ptr <= '0;
    else if (r_state == ST_REQ && w_state_nxt == ST_XFER)
      r_rr_ptr <= f_wrap_idx(r_active_ch, 1);
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_elig[i]) w_win = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_cnt_nxt = '0;
    w_active_nxt  = r_active_ch;
    w_bus_req_nxt = 1'b0;
    w_hold_nxt    = 1'b0;
    w_con_en_nxt  = 1'b0;
    w_ch_en_nxt   = '0;
    w_req_ack_nxt = '0;
    w_irq_nxt     = 1'b0;
    w_tmo_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt   = ST_REQ;
          w_active_nxt  = w_win;
          w_bus_req_nxt = 1'b1;
          w_hold_nxt    = 1'b1;
        end
      end
      ST_REQ: begin
        // A withdrawn request takes precedence over a simultaneous grant.
        if (!dmac_req[r_active_ch]) begin
          w_state_nxt = ST_IDLE;
        end else if (bus_grant && c_config) begin
          w_state_nxt   = ST_XFER;
          w_bus_req_nxt = 1'b1;
          w_hold_nxt    = 1'b1;
          w_con_en_nxt  = 1'b1;
          w_ch_en_nxt   = w_onehot;
          w_req_ack_nxt = w_onehot;
        end else if (r_tmo_cnt == C_TMO_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_tmo_err_nxt = 1'b1;
        end else begin
          w_bus_req_nxt = 1'b1;
          w_hold_nxt    = 1'b1;
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      ST_XFER: begin
        if (ch_done) begin
          w_state_nxt = ST_IDLE;
          w_irq_nxt   = 1'b1;
        end else begin
          w_bus_req_nxt = 1'b1;
          w_hold_nxt    = 1'b1;
          w_con_en_nxt  = 1'b1;
          w_ch_en_nxt   = bus_grant ? w_onehot : '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_active_ch <= '0;
      r_bus_req   <= 1'b0;
      r_hold      <= 1'b0;
      r_con_en    <= 1'b0;
      r_ch_en     <= '0;
      r_req_ack   <= '0;
      r_irq       <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_active_ch <= w_active_nxt;
      r_bus_req   <= w_bus_req_nxt;
      r_hold      <= w_hold_nxt;
      r_con_en    <= w_con_en_nxt;
      r_ch_en     <= w_ch_en_nxt;
      r_req_ack   <= w_req_ack_nxt;
      r_irq       <= w_irq_nxt;
      r_tmo_err   <= w_tmo_err_nxt;
    end
  end

  assign bus_req     = r_bus_req;
  assign hold        = r_hold;
  assign con_en      = r_con_en;
  assign con_sel     = (r_state == ST_XFER) ? con_new_sel : 1'b0;
  assign ch_en       = r_ch_en;
  assign req_ack     = r_req_ack;
  assign active_ch   = r_active_ch;
  assign interrupt   = r_irq;
  assign timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_dmac_multi_chan_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_dmac_multi_chan_ctrl
// Brief  : Directed bench for dmac_multi_chan_ctrl with a transaction-level reference model.
// Rev    : 1.0
//==============================================================================
module tb_dmac_multi_chan_ctrl;

  localparam int NUM_CH        = 4;
  localparam int TMO_W         = 8;
  localparam int GRANT_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dmac_req = 4'b0;
  logic [3:0] ch_mask = 4'b0;
  logic       bus_grant = 1'b0;
  logic       c_config = 1'b0;
  logic       ch_done = 1'b0;
  logic       con_new_sel = 1'b0;
  logic       bus_req, hold, con_en, con_sel, interrupt, timeout_err;
  logic [3:0] ch_en, req_ack;
  logic [1:0] active_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmac_multi_chan_ctrl #(
    .NUM_CH       (NUM_CH),
    .TMO_W        (TMO_W),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dmac_req   (dmac_req),
    .ch_mask    (ch_mask),
    .bus_grant  (bus_grant),
    .c_config   (c_config),
    .ch_done    (ch_done),
    .con_new_sel(con_new_sel),
    .bus_req    (bus_req),
    .hold       (hold),
    .con_en     (con_en),
    .con_sel    (con_sel),
    .ch_en      (ch_en),
    .req_ack    (req_ack),
    .active_ch  (active_ch),
    .interrupt  (interrupt),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner channel (-1 = none), whether the bus was won, and cycles waited.
  int         m_owner   = -1;
  bit         m_granted = 1'b0;
  int         m_wait    = 0;
  bit         m_valid   = 1'b0;
`ifdef DMAC_RR_ARB_EN
  int         m_rr_next = 0;
`endif
  logic       e_bus_req = 1'b0, e_hold = 1'b0, e_con_en = 1'b0;
  logic       e_irq = 1'b0, e_tmo = 1'b0;
  logic [3:0] e_ch_en = 4'b0, e_req_ack = 4'b0;
  logic [1:0] e_active = 2'b0;

  function automatic int pick(input logic [3:0] elig);
`ifdef DMAC_RR_ARB_EN
    for (int k = 0; k < NUM_CH; k++)
      if (elig[(m_rr_next + k) % NUM_CH]) return (m_rr_next + k) % NUM_CH;
`else
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (elig[i]) return i;
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [3:0] elig;
    m_valid = 1'b1;
    if (rst) begin
      m_owner = -1; m_granted = 1'b0; m_wait = 0;
`ifdef DMAC_RR_ARB_EN
      m_rr_next = 0;
`endif
      e_bus_req = 0; e_hold = 0; e_con_en = 0; e_irq = 0; e_tmo = 0;
      e_ch_en = 0; e_req_ack = 0; e_active = 0;
    end else begin
      e_req_ack = 0; e_irq = 0; e_tmo = 0;
      if (m_owner < 0) begin
        elig = dmac_req & ch_mask;
        if (elig != 4'b0) begin
          m_owner = pick(elig); m_wait = 0;
          e_active = 2'(m_owner); e_bus_req = 1; e_hold = 1;
        end
      end else if (!m_granted) begin
        if (!dmac_req[m_owner]) begin
          m_owner = -1; e_bus_req = 0; e_hold = 0;
        end else if (bus_grant && c_config) begin
          m_granted = 1'b1;
          e_req_ack = 4'(1 << m_owner); e_ch_en = 4'(1 << m_owner); e_con_en = 1;
`ifdef DMAC_RR_ARB_EN
          m_rr_next = (m_owner + 1) % NUM_CH;
`endif
        end else if (m_wait + 1 == GRANT_TIMEOUT) begin
          m_owner = -1; e_tmo = 1; e_bus_req = 0; e_hold = 0;
        end else begin
          m_wait++;
        end
      end else begin
        if (ch_done) begin
          m_owner = -1; m_granted = 1'b0;
          e_irq = 1; e_ch_en = 0; e_hold = 0; e_bus_req = 0; e_con_en = 0;
        end else begin
          e_ch_en = bus_grant ? 4'(1 << m_owner) : 4'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_bus_req", 32'(bus_req), 32'(e_bus_req));
      chk("m_hold", 32'(hold), 32'(e_hold));
      chk("m_con_en", 32'(con_en), 32'(e_con_en));
      chk("m_con_sel", 32'(con_sel), 32'(m_granted ? con_new_sel : 1'b0));
      chk("m_ch_en", 32'(ch_en), 32'(e_ch_en));
      chk("m_req_ack", 32'(req_ack), 32'(e_req_ack));
      chk("m_active_ch", 32'(active_ch), 32'(e_active));
      chk("m_interrupt", 32'(interrupt), 32'(e_irq));
      chk("m_timeout_err", 32'(timeout_err), 32'(e_tmo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch;
    rst = 1'b1; ch_mask = 4'hF;
    tick(); tick();
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_ch_en", 32'(ch_en), 0);
    chk("rst_active_ch", 32'(active_ch), 0);
    chk("rst_interrupt", 32'(interrupt), 0);
    rst = 1'b0;

    // single request on ch2
    dmac_req = 4'b0100; tick();
    chk("t1_bus_req", 32'(bus_req), 1);
    chk("t1_hold", 32'(hold), 1);
    chk("t1_active_ch", 32'(active_ch), 2);
    tick(); tick();
    bus_grant = 1; c_config = 1; tick();
    chk("t1_req_ack", 32'(req_ack), 32'h4);
    chk("t1_ch_en", 32'(ch_en), 32'h4);
    chk("t1_con_en", 32'(con_en), 1);
    tick();
    chk("t1_ack_pulse", 32'(req_ack), 0);
    dmac_req = 4'b0; ch_done = 1; tick();
    chk("t1_interrupt", 32'(interrupt), 1);
    chk("t1_ch_en_off", 32'(ch_en), 0);
    chk("t1_bus_req_off", 32'(bus_req), 0);
    ch_done = 0; bus_grant = 0; c_config = 0; tick();
    chk("t1_irq_pulse", 32'(interrupt), 0);

    // two requesters, request held across completion
    dmac_req = 4'b1010; tick();
    chk("t2_active_ch", 32'(active_ch), 3);
    bus_grant = 1; c_config = 1; tick();
    chk("t2_req_ack", 32'(req_ack), 32'h8);
    ch_done = 1; tick();
    chk("t2_interrupt", 32'(interrupt), 1);
    ch_done = 0; tick();
`ifdef DMAC_RR_ARB_EN
    exp_ch = 1;
`else
    exp_ch = 3;
`endif
    chk("t2_second_active", 32'(active_ch), 32'(exp_ch));
    tick();
    chk("t2_second_ack", 32'(1 << exp_ch), 32'(req_ack));
    ch_done = 1; tick();
    ch_done = 0; dmac_req = 4'b0; bus_grant = 0; c_config = 0; tick();

    // all four requesting from reset
    rst = 1; tick(); rst = 0;
    dmac_req = 4'hF; bus_grant = 1; c_config = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef DMAC_RR_ARB_EN
      exp_ch = t;
`else
      exp_ch = 3;
`endif
      tick();
      chk("t3_active_ch", 32'(active_ch), 32'(exp_ch));
      tick();
      chk("t3_req_ack", 32'(req_ack), 32'(1 << exp_ch));
      ch_done = 1; tick();
      chk("t3_interrupt", 32'(interrupt), 1);
      ch_done = 0;
    end
    dmac_req = 4'b0; bus_grant = 0; c_config = 0; tick();

    // grant never arrives: timeout after 16 REQ cycles
    dmac_req = 4'b0001; tick();
    chk("t4_bus_req", 32'(bus_req), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t4_no_tmo_yet", 32'({bus_req, timeout_err}), 32'b10);
    end
    tick();
    chk("t4_timeout_err", 32'(timeout_err), 1);
    chk("t4_bus_req_drop", 32'(bus_req), 0);
    tick();
    chk("t4_rerequest", 32'({bus_req, timeout_err}), 32'b10);
    dmac_req = 4'b0; tick();
    chk("t4_withdraw", 32'({bus_req, req_ack}), 0);

    // grant loss pauses the transfer
    dmac_req = 4'b0010; bus_grant = 1; c_config = 1; con_new_sel = 1; tick();
    chk("t5_con_sel_req", 32'(con_sel), 0);
    tick();
    chk("t5_ch_en", 32'(ch_en), 32'h2);
    chk("t5_con_sel_xfer", 32'(con_sel), 1);
    ch_mask = 4'b0; bus_grant = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_paused", 32'({ch_en, hold, interrupt}), 32'b0000_1_0);
    end
    bus_grant = 1; tick();
    chk("t5_resumed", 32'(ch_en), 32'h2);
    ch_mask = 4'hF; ch_done = 1; tick();
    chk("t5_interrupt", 32'(interrupt), 1);
    ch_done = 0; dmac_req = 4'b0; con_new_sel = 0; bus_grant = 0; c_config = 0; tick();

    // reset mid-transfer, then fully masked requests
    dmac_req = 4'b0100; bus_grant = 1; c_config = 1; tick(); tick();
    chk("t6_ch_en", 32'(ch_en), 32'h4);
    #2 rst = 1;
    #1;
    chk("t6_rst_outputs", 32'({bus_req, hold, con_en, con_sel, ch_en, req_ack, active_ch, interrupt, timeout_err}), 0);
    tick(); rst = 0;
    bus_grant = 0; c_config = 0; ch_mask = 4'b0; dmac_req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_masked_idle", 32'(bus_req), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
